// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image over a byte stream, packs it into
// little-endian 32-bit words, writes them to instruction memory and releases the CPU.
module imem_boot_loader #(
  parameter int unsigned DEPTH     = 1001,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] MEM_addr,
  output logic [31:0] MEM_Wdata,
  output logic        wMEM_en,
  output logic        cpu_rst_n,
  output logic        boot_done,
  output logic        boot_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE
  } state_e;

  localparam logic [15:0] MAX_LEN = 16'(DEPTH);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        wmem_en_q, wmem_en_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic        boot_done_q, boot_done_d;
  logic        boot_err_q, boot_err_d;
  logic        busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wmem_en_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      boot_done_q <= 1'b0;
      boot_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wmem_en_q   <= wmem_en_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      boot_done_q <= boot_done_d;
      boot_err_q  <= boot_err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    csum_d      = csum_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wmem_en_d   = 1'b0;
    cpu_rst_n_d = cpu_rst_n_q;
    boot_done_d = boot_done_q;
    boot_err_d  = boot_err_q;

    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d    = LEN_LO;
            boot_err_d = 1'b0;
            csum_d     = '0;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            len_d      = '0;
          end
        end
        LEN_LO: begin
          len_d   = {8'h00, rx_data};
          state_d = LEN_HI;
        end
        LEN_HI: begin
          len_d = {rx_data, len_q[7:0]};
          if ((len_d == 16'd0) || (len_d > MAX_LEN)) begin
            state_d    = IDLE;
            boot_err_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          csum_d     = csum_q + rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    word_d[7:0]   = rx_data;
            2'd1:    word_d[15:8]  = rx_data;
            2'd2:    word_d[23:16] = rx_data;
            default: word_d[31:24] = rx_data;
          endcase
          // The 4th byte goes straight to the write port so the strobe lands next cycle.
          if (byte_cnt_q == 2'd3) begin
            wmem_en_d   = 1'b1;
            mem_addr_d  = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
            mem_wdata_d = {rx_data, word_q[23:0]};
            word_cnt_d  = word_cnt_q + 16'd1;
            if (word_cnt_q == (len_q - 16'd1)) begin
              state_d = CSUM;
            end
          end
        end
        CSUM: begin
          if (rx_data == csum_q) begin
            state_d     = DONE;
            cpu_rst_n_d = 1'b1;
            boot_done_d = 1'b1;
          end else begin
            state_d    = IDLE;
            boot_err_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    busy_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
             (state_d == DATA)   || (state_d == CSUM);
  end

  assign MEM_addr  = mem_addr_q;
  assign MEM_Wdata = mem_wdata_q;
  assign wMEM_en   = wmem_en_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign boot_done = boot_done_q;
  assign boot_err  = boot_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: frames are driven byte by byte and the
// write port is logged so addresses, data and strobe timing can be checked.
module tb_imem_boot_loader;

  typedef logic [7:0] byteQ_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_Wdata;
  logic        wMEM_en;
  logic        cpu_rst_n;
  logic        boot_done;
  logic        boot_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCyc[$];
  int          drvCyc[$];

  byteQ_t goodFrame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
                        8'h93, 8'h80, 8'h10, 8'h00, 8'h46};
  byteQ_t badFrame  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00,
                        8'h93, 8'h80, 8'h10, 8'h00, 8'h47};

  imem_boot_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .MEM_addr (MEM_addr),
    .MEM_Wdata(MEM_Wdata),
    .wMEM_en  (wMEM_en),
    .cpu_rst_n(cpu_rst_n),
    .boot_done(boot_done),
    .boot_err (boot_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Log every write strobe with the cycle in which it was visible.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (wMEM_en === 1'b1) begin
      wrAddr.push_back(MEM_addr);
      wrData.push_back(MEM_Wdata);
      wrCyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrCyc.delete();
  endtask

  task automatic applyStimulus(input byteQ_t frame, input bit backToBack);
    drvCyc.delete();
    foreach (frame[i]) begin
      @(negedge clk);
      rx_data  = frame[i];
      rx_valid = 1'b1;
      drvCyc.push_back(cyc);
      if (!backToBack) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clearLog();
  endtask

  function automatic logic [31:0] logAddr(input int idx);
    return (wrAddr.size() > idx) ? wrAddr[idx] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] logData(input int idx);
    return (wrData.size() > idx) ? wrData[idx] : 32'hDEAD_BEEF;
  endfunction

  function automatic int logCyc(input int idx);
    return (wrCyc.size() > idx) ? wrCyc[idx] : -1;
  endfunction

  task automatic checkGoodLoad(input string tag);
    checkOutput({tag, " writes"}, wrAddr.size(), 2);
    checkOutput({tag, " addr0"}, logAddr(0), 32'h0000_0000);
    checkOutput({tag, " data0"}, logData(0), 32'h0010_0013);
    checkOutput({tag, " addr1"}, logAddr(1), 32'h0000_0004);
    checkOutput({tag, " data1"}, logData(1), 32'h0010_8093);
    checkOutput({tag, " cpu_rst_n"}, cpu_rst_n, 1);
    checkOutput({tag, " boot_done"}, boot_done, 1);
    checkOutput({tag, " boot_err"}, boot_err, 0);
    checkOutput({tag, " busy"}, busy, 0);
  endtask

  initial begin
    #1;
    checkOutput("reset MEM_addr", MEM_addr, 0);
    checkOutput("reset MEM_Wdata", MEM_Wdata, 0);
    checkOutput("reset wMEM_en", wMEM_en, 0);
    checkOutput("reset cpu_rst_n", cpu_rst_n, 0);
    checkOutput("reset boot_done", boot_done, 0);
    checkOutput("reset boot_err", boot_err, 0);
    checkOutput("reset busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clearLog();

    // Good load with gaps between bytes
    applyStimulus(goodFrame, 1'b0);
    checkGoodLoad("t1");
    checkOutput("t1 addr held", MEM_addr, 32'h0000_0004);
    checkOutput("t1 data held", MEM_Wdata, 32'h0010_8093);
    clearLog();
    applyStimulus(goodFrame, 1'b0);
    checkOutput("t1 done ignores writes", wrAddr.size(), 0);
    checkOutput("t1 done sticky", boot_done, 1);

    // Bad checksum, then the good frame again
    doReset();
    applyStimulus(badFrame, 1'b0);
    checkOutput("t2 writes", wrAddr.size(), 2);
    checkOutput("t2 boot_err", boot_err, 1);
    checkOutput("t2 cpu_rst_n", cpu_rst_n, 0);
    checkOutput("t2 boot_done", boot_done, 0);
    checkOutput("t2 busy idle", busy, 0);
    clearLog();
    applyStimulus(goodFrame, 1'b0);
    checkGoodLoad("t2 resend");

    // Length boundaries
    doReset();
    applyStimulus('{8'hA5, 8'h00, 8'h00}, 1'b0);
    checkOutput("t3 len0 boot_err", boot_err, 1);
    checkOutput("t3 len0 writes", wrAddr.size(), 0);
    checkOutput("t3 len0 busy", busy, 0);
    applyStimulus('{8'hA5, 8'hEA, 8'h03}, 1'b0);
    checkOutput("t3 len1002 boot_err", boot_err, 1);
    checkOutput("t3 len1002 busy", busy, 0);
    applyStimulus('{8'hA5, 8'hE9, 8'h03}, 1'b0);
    checkOutput("t3 len1001 busy", busy, 1);
    checkOutput("t3 len1001 boot_err", boot_err, 0);
    checkOutput("t3 len1001 writes", wrAddr.size(), 0);

    // Garbage ahead of the sync byte
    doReset();
    applyStimulus('{8'h00, 8'hFF, 8'h13}, 1'b0);
    checkOutput("t4 garbage busy", busy, 0);
    checkOutput("t4 garbage boot_err", boot_err, 0);
    applyStimulus(goodFrame, 1'b0);
    checkGoodLoad("t4");

    // Back-to-back bytes: strobe one cycle after each 4th data byte
    doReset();
    applyStimulus(goodFrame, 1'b1);
    checkGoodLoad("t5");
    checkOutput("t5 strobe0 cycle", logCyc(0), drvCyc[6] + 1);
    checkOutput("t5 strobe1 cycle", logCyc(1), drvCyc[10] + 1);

    // Reset in the middle of a frame
    doReset();
    applyStimulus('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93}, 1'b0);
    checkOutput("t6 pre-reset data", MEM_Wdata, 32'h0010_0013);
    checkOutput("t6 pre-reset busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 rst MEM_addr", MEM_addr, 0);
    checkOutput("t6 rst MEM_Wdata", MEM_Wdata, 0);
    checkOutput("t6 rst wMEM_en", wMEM_en, 0);
    checkOutput("t6 rst cpu_rst_n", cpu_rst_n, 0);
    checkOutput("t6 rst boot_done", boot_done, 0);
    checkOutput("t6 rst boot_err", boot_err, 0);
    checkOutput("t6 rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clearLog();
    applyStimulus(goodFrame, 1'b0);
    checkGoodLoad("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
